// File: rtl/branch_resolve_ctrl.sv
// Branch/jump resolution: captures one request, derives compare flags with a subtractor,
// decodes taken/target/link and holds the result until consumed. Optional BRANCH_PRED_EN adds misprediction output and counters.
module branch_resolve_ctrl #(
  parameter int XLEN       = 32,
  parameter int ILEN_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_unsigned,
  input  logic [2:0]      in_branch_src,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
`ifdef BRANCH_PRED_EN
  input  logic            in_pred_taken,
  output logic            out_mispredict,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts,
`endif
  output logic [1:0]      dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are both high;
  // in_ready is high only in IDLE, out_valid only in RESP; flush overrides both.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

  state_t state, state_n;

  logic            uns_q;
  logic [2:0]      src_q;
  logic [XLEN-1:0] rs1_q, rs2_q, pc_q, imm_q;

  logic [XLEN:0]   diff;
  logic            zero, carry, negative, overflow;
  logic            c_eq, c_lt, c_le, taken_c;
  logic            capture, exec_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (in_valid)  state_n = S_EXEC;
      S_EXEC:                 state_n = S_RESP;
      S_RESP:  if (out_ready) state_n = S_IDLE;
      default:                state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_RESP);
    dbg_state = state;
  end

  assign capture   = (state == S_IDLE) && in_valid && !flush;
  assign exec_fire = (state == S_EXEC) && !flush;

  // rs1 - rs2 as rs1 + ~rs2 + 1; the extra top bit is the unsigned no-borrow carry.
  assign diff     = {1'b0, rs1_q} + {1'b0, ~rs2_q} + {{XLEN{1'b0}}, 1'b1};
  assign zero     = (diff[XLEN-1:0] == '0);
  assign carry    = diff[XLEN];
  assign negative = diff[XLEN-1];
  assign overflow = (rs1_q[XLEN-1] != rs2_q[XLEN-1]) && (diff[XLEN-1] != rs1_q[XLEN-1]);

  always_comb begin
    c_eq = zero;
    c_lt = uns_q ? !carry : (negative ^ overflow);
    c_le = c_lt || zero;
    case (src_q)
      3'd0:    taken_c = c_eq;
      3'd1:    taken_c = !c_eq;
      3'd2:    taken_c = c_lt;
      3'd3:    taken_c = !c_le;
      3'd4:    taken_c = c_le;
      3'd5:    taken_c = !c_lt;
      3'd6:    taken_c = 1'b1;
      default: taken_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uns_q <= 1'b0;
      src_q <= 3'd0;
      rs1_q <= '0;
      rs2_q <= '0;
      pc_q  <= '0;
      imm_q <= '0;
    end else if (capture) begin
      uns_q <= in_unsigned;
      src_q <= in_branch_src;
      rs1_q <= in_rs1;
      rs2_q <= in_rs2;
      pc_q  <= in_pc;
      imm_q <= in_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_taken  <= 1'b0;
      out_target <= '0;
      out_link   <= '0;
    end else if (exec_fire) begin
      out_taken  <= taken_c;
      out_target <= taken_c ? (pc_q + imm_q) : (pc_q + XLEN'(ILEN_BYTES));
      out_link   <= pc_q + XLEN'(ILEN_BYTES);
    end
  end

`ifdef BRANCH_PRED_EN
  logic pred_q;
  logic resp_hs;

  assign resp_hs        = out_valid && out_ready;
  assign out_mispredict = out_taken ^ pred_q;

  // Counters track consumed results only, so a flush never rolls them back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_q           <= 1'b0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (capture) pred_q <= in_pred_taken;
      if (resp_hs && stat_branches != 32'hFFFF_FFFF)
        stat_branches <= stat_branches + 32'd1;
      if (resp_hs && out_mispredict && stat_mispredicts != 32'hFFFF_FFFF)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed vector table, randomized requests against a
// compare-level model, and hand-written flush/backpressure/reset sequences. Honors BRANCH_PRED_EN.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_unsigned = 1'b0;
  logic [2:0]  in_branch_src = 3'd0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0, in_pc = '0, in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_taken;
  logic [31:0] out_target, out_link;
  logic [1:0]  dbg_state;
`ifdef BRANCH_PRED_EN
  logic        in_pred_taken = 1'b0;
  logic        out_mispredict;
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];
  int exp_br = 0;
  int exp_mp = 0;

  branch_resolve_ctrl #(.XLEN(32), .ILEN_BYTES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_unsigned(in_unsigned), .in_branch_src(in_branch_src),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_target(out_target), .out_link(out_link),
`ifdef BRANCH_PRED_EN
    .in_pred_taken(in_pred_taken), .out_mispredict(out_mispredict),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        uns;
    logic [2:0]  src;
    logic [31:0] rs1, rs2, pc, imm;
    logic        pred;
    int          hold;
    logic        taken;
    logic [31:0] target, link;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Reference: plain integer comparisons, no flag arithmetic.
  function automatic logic ref_taken(input logic uns, input logic [2:0] src,
                                     input logic [31:0] a, input logic [31:0] b);
    logic eq, lt;
    eq = (a == b);
    lt = uns ? (a < b) : ($signed(a) < $signed(b));
    case (src)
      3'd0: return eq;
      3'd1: return !eq;
      3'd2: return lt;
      3'd3: return !(lt || eq);
      3'd4: return lt || eq;
      3'd5: return !lt;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_req(input logic uns, input logic [2:0] src, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] pc, input logic [31:0] imm,
                           input logic pred);
    in_unsigned = uns; in_branch_src = src;
    in_rs1 = rs1; in_rs2 = rs2; in_pc = pc; in_imm = imm;
`ifdef BRANCH_PRED_EN
    in_pred_taken = pred;
`else
    if (pred) in_unsigned = uns;
`endif
    in_valid = 1'b1;
  endtask

  // Full transaction: accept, EXEC, RESP with optional backpressure, consume. Called at negedge.
  task automatic run_req(input logic uns, input logic [2:0] src, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] pc, input logic [31:0] imm,
                         input logic pred, input int hold);
    logic [64:0] e;
    logic [31:0] t0, l0;
    logic        k0;
    check1("idle_ready", in_ready, 1'b1);
    drive_req(uns, src, rs1, rs2, pc, imm, pred);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check1("exec_ready_low", in_ready, 1'b0);
    check1("exec_no_valid", out_valid, 1'b0);
    @(negedge clk);
    check1("resp_valid", out_valid, 1'b1);
    check1("resp_ready_low", in_ready, 1'b0);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      e = '0;
    end else e = exp_q.pop_front();
    check1("taken", out_taken, e[64]);
    check("target", out_target, e[63:32]);
    check("link", out_link, e[31:0]);
`ifdef BRANCH_PRED_EN
    check1("mispredict", out_mispredict, e[64] ^ pred);
`endif
    k0 = out_taken; t0 = out_target; l0 = out_link;
    for (int h = 0; h < hold; h++) begin
      drive_req(~uns, src + 3'd1, ~rs1, rs2, pc + 32'h40, imm, pred);
      @(negedge clk);
      check1("hold_valid", out_valid, 1'b1);
      check1("hold_ready_low", in_ready, 1'b0);
      check1("hold_taken", out_taken, k0);
      check("hold_target", out_target, t0);
      check("hold_link", out_link, l0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    exp_br++;
    if (e[64] != pred) exp_mp++;
    @(negedge clk);
    out_ready = 1'b0;
    check1("done_valid_low", out_valid, 1'b0);
    check1("done_ready_high", in_ready, 1'b1);
  endtask

  task automatic push_exp(input logic taken, input logic [31:0] pc, input logic [31:0] imm);
    exp_q.push_back({taken, taken ? pc + imm : pc + 32'd4, pc + 32'd4});
  endtask

  task automatic check_stats(input string tag);
`ifdef BRANCH_PRED_EN
    check({tag, "_stat_branches"}, stat_branches, exp_br);
    check({tag, "_stat_mispredicts"}, stat_mispredicts, exp_mp);
`else
    if (tag.len() == 0) exp_mp = exp_br;
`endif
  endtask

  initial begin
    vecs[0] = '{1'b0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 0, 1'b1, 32'h120, 32'h104};
    vecs[1] = '{1'b0, 3'd2, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b1, 1, 1'b1, 32'h240, 32'h204};
    vecs[2] = '{1'b1, 3'd2, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b0, 5, 1'b0, 32'h204, 32'h204};
    vecs[3] = '{1'b0, 3'd2, 32'h80000000, 32'd1, 32'h300, 32'hFFFFFFF0, 1'b1, 0, 1'b1, 32'h2F0, 32'h304};
    vecs[4] = '{1'b0, 3'd5, 32'h7FFFFFFF, 32'h80000000, 32'h400, 32'h8, 1'b1, 0, 1'b1, 32'h408, 32'h404};
    vecs[5] = '{1'b0, 3'd6, 32'd0, 32'd9, 32'hFFFFFFF0, 32'h20, 1'b0, 0, 1'b1, 32'h10, 32'hFFFFFFF4};
    vecs[6] = '{1'b0, 3'd7, 32'd1, 32'd1, 32'h10, 32'h100, 1'b0, 0, 1'b0, 32'h14, 32'h14};
    vecs[7] = '{1'b0, 3'd1, 32'd3, 32'd3, 32'h20, 32'h4, 1'b0, 0, 1'b0, 32'h24, 32'h24};
    vecs[8] = '{1'b1, 3'd3, 32'h80000000, 32'd1, 32'h40, 32'h10, 1'b1, 0, 1'b1, 32'h50, 32'h44};
    vecs[9] = '{1'b0, 3'd4, 32'h80000000, 32'd1, 32'h60, 32'h20, 1'b1, 2, 1'b1, 32'h80, 32'h64};

    // reset values, checked while reset is still asserted
    #12;
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_taken", out_taken, 1'b0);
    check("rst_target", out_target, 32'd0);
    check("rst_link", out_link, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check_stats("rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // directed table
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({vecs[i].taken, vecs[i].target, vecs[i].link});
      run_req(vecs[i].uns, vecs[i].src, vecs[i].rs1, vecs[i].rs2, vecs[i].pc, vecs[i].imm,
              vecs[i].pred, vecs[i].hold);
    end
    check_stats("table");

    // randomized requests against the model
    for (int i = 0; i < 40; i++) begin
      logic uns, pred, tk;
      logic [2:0] src;
      logic [31:0] a, b, pc, imm;
      uns  = 1'($urandom_range(0, 1));
      pred = 1'($urandom_range(0, 1));
      src  = 3'($urandom_range(0, 7));
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = {~a[31], a[30:0]};
      pc   = $urandom;
      imm  = $urandom;
      tk   = ref_taken(uns, src, a, b);
      push_exp(tk, pc, imm);
      run_req(uns, src, a, b, pc, imm, pred, $urandom_range(0, 2));
    end
    check_stats("random");

    // flush in EXEC
    drive_req(1'b0, 3'd6, 32'd0, 32'd0, 32'h500, 32'h10, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check1("flush_exec_valid", out_valid, 1'b0);
    check1("flush_exec_ready", in_ready, 1'b1);
    @(negedge clk);
    check1("flush_exec_no_resp", out_valid, 1'b0);

    // flush in RESP drops the unconsumed result
    drive_req(1'b0, 3'd6, 32'd0, 32'd0, 32'h600, 32'h10, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check1("flush_resp_pre", out_valid, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check1("flush_resp_valid", out_valid, 1'b0);
    check1("flush_resp_ready", in_ready, 1'b1);

    // flush with in_valid in IDLE: request rejected
    drive_req(1'b0, 3'd6, 32'd0, 32'd0, 32'h700, 32'h10, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check1("flush_idle_ready", in_ready, 1'b1);
    @(negedge clk);
    check1("flush_idle_no_exec", in_ready, 1'b1);
    @(negedge clk);
    check1("flush_idle_no_resp", out_valid, 1'b0);
    check_stats("flush");

    // flush coinciding with consume counts as consumed
    drive_req(1'b0, 3'd6, 32'd0, 32'd0, 32'h800, 32'h10, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check1("flushhs_pre", out_valid, 1'b1);
    flush = 1'b1;
    out_ready = 1'b1;
    exp_br++;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    check1("flushhs_valid", out_valid, 1'b0);
    check1("flushhs_ready", in_ready, 1'b1);
    check_stats("flushhs");

    // asynchronous reset in RESP
    push_exp(1'b1, 32'h900, 32'h10);
    drive_req(1'b0, 3'd6, 32'd0, 32'd0, 32'h900, 32'h10, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check1("midrst_pre", out_valid, 1'b1);
    check("midrst_pre_target", out_target, exp_q[0][63:32]);
    void'(exp_q.pop_front());
    #2 rst = 1'b1;
    #1;
    exp_br = 0;
    exp_mp = 0;
    check1("midrst_valid", out_valid, 1'b0);
    check1("midrst_ready", in_ready, 1'b1);
    check1("midrst_taken", out_taken, 1'b0);
    check("midrst_target", out_target, 32'd0);
    check("midrst_link", out_link, 32'd0);
    check_stats("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // one more transaction after reset
    push_exp(1'b1, 32'h1000, 32'h8);
    run_req(1'b0, 3'd0, 32'd7, 32'd7, 32'h1000, 32'h8, 1'b0, 1);
    check_stats("final");
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
